reg_bank_reader: RTL and testbench

Read-side companion to the register/ALU datapath. It walks a range of the 32-bit register bank through one read port and presents each register as two 16-bit halves on the board display. Halves advance either on a manual step pulse or on an automatic dwell timer. It drives the register bank's read address and consumes that port's combinational read data.

---
 rtl/reg_bank_reader_pkg.sv | 17 +
 rtl/reg_bank_reader_dwell_timer.sv | 29 ++
 rtl/reg_bank_reader.sv | 109 ++++++++++
 tb/tb_reg_bank_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_reader_pkg.sv
// Shared widths and FSM state encoding for the register bank reader.
package reg_bank_reader_pkg;

  localparam int REG_IDX_W  = 4;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int DISP_W     = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    SHOW_LO = 3'd2,
    SHOW_HI = 3'd3,
    FINISH  = 3'd4
  } state_t;

endpackage

// File: rtl/reg_bank_reader_dwell_timer.sv
// Dwell counter: expire is high in the last of every DWELL_CYCLES enabled cycles.
module dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(DWELL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank_reader.sv
// Walks a wrapping range of the register bank and shows each register as two
// 16-bit halves, advancing on a step pulse or on the dwell timer.
module reg_bank_reader
  import reg_bank_reader_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  auto_mode,
  input  logic                  step,
  input  logic [REG_IDX_W-1:0]  first_reg,
  input  logic [REG_IDX_W-1:0]  last_reg,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic [DISP_W-1:0]     display_output,
  output logic [REG_IDX_W-1:0]  cur_reg,
  output logic                  half,
  output logic                  busy,
  output logic                  done
);

  state_t               state;
  logic [REG_IDX_W-1:0] idx;
  logic [REG_IDX_W-1:0] last_q;
  logic                 auto_q;
  logic [DATA_W-1:0]    data_q;
  logic                 in_show;
  logic                 timer_expire;
  logic                 advance;

  assign in_show = (state == SHOW_LO) || (state == SHOW_HI);
  assign advance = in_show && (auto_q ? timer_expire : step);
  assign rd_addr = {1'b0, idx};
  assign busy    = (state != IDLE);

  // Held clear outside the SHOW states and on every advance, so each half
  // starts its dwell from zero.
  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_show || advance),
    .enable (in_show && auto_q),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      idx            <= '0;
      last_q         <= '0;
      auto_q         <= 1'b0;
      data_q         <= '0;
      display_output <= '0;
      cur_reg        <= '0;
      half           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state != IDLE)) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              idx    <= first_reg;
              last_q <= last_reg;
              auto_q <= auto_mode;
              state  <= READ;
            end
          end
          READ: begin
            // Low half is loaded straight from the read port on the capture edge.
            data_q         <= rd_data;
            cur_reg        <= idx;
            display_output <= rd_data[DISP_W-1:0];
            half           <= 1'b0;
            state          <= SHOW_LO;
          end
          SHOW_LO: begin
            display_output <= advance ? data_q[DATA_W-1:DISP_W] : data_q[DISP_W-1:0];
            if (advance) begin
              half  <= 1'b1;
              state <= SHOW_HI;
            end
          end
          SHOW_HI: begin
            if (advance) begin
              if (idx == last_q) begin
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                idx   <= idx + 1'b1;
                state <= READ;
              end
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_reader.sv
// Self-checking bench for reg_bank_reader: table-driven and random dumps against
// a range/visit-order model, plus hand-written abort, restart and snapshot cases.
module tb_reg_bank_reader;

  localparam int DWELL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        auto_mode = 1'b0;
  logic        step = 1'b0;
  logic [3:0]  first_reg = 4'd0;
  logic [3:0]  last_reg = 4'd0;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [15:0] display_output;
  logic [3:0]  cur_reg;
  logic        half;
  logic        busy;
  logic        done;

  logic [31:0] bank [0:31];
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] f;
    logic [3:0] l;
    logic       am;
    int         nregs;
  } vec_t;

  vec_t tbl [5];

  assign rd_data = bank[rd_addr];

  always #5 clk = ~clk;

  reg_bank_reader #(
    .DWELL_CYCLES(DWELL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .auto_mode      (auto_mode),
    .step           (step),
    .first_reg      (first_reg),
    .last_reg       (last_reg),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .display_output (display_output),
    .cur_reg        (cur_reg),
    .half           (half),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic kick(input logic [3:0] f, input logic [3:0] l, input logic am);
    first_reg = f;
    last_reg  = l;
    auto_mode = am;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    first_reg = 4'($urandom);
    last_reg  = 4'($urandom);
    auto_mode = ~am;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) bank[i] = $urandom;
  endtask

  // Model: registers visited are f, f+1, ... (mod 16) ending at l; each half
  // shows the word captured at READ for DWELL cycles (auto) or until step.
  task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input logic am,
                          input int exp_regs, input string tag);
    logic [31:0] word;
    logic [3:0]  e;
    logic [3:0]  nx;
    int          cnt;
    int          nregs;
    nregs = 18;
    word  = '0;
    kick(f, l, am);
    chk({tag, " rd_addr_first"}, rd_addr, {1'b0, f});
    for (int k = 0; k < 18; k++) begin
      e    = 4'(int'(f) + k);
      word = bank[e];
      @(negedge clk);
      chk({tag, " cur_reg"}, cur_reg, e);
      chk({tag, " lo_half_flag"}, half, 1'b0);
      chk({tag, " lo_display"}, display_output, word[15:0]);
      chk({tag, " busy_show"}, busy, 1'b1);
      if (am) begin
        cnt = 1;
        @(negedge clk);
        while (half == 1'b0 && cnt < 12) begin
          cnt++;
          @(negedge clk);
        end
        chk({tag, " dwell_lo"}, cnt, DWELL);
      end else begin
        repeat (5) @(negedge clk);
        chk({tag, " lo_hold"}, half, 1'b0);
        pulse_step();
      end
      chk({tag, " hi_half_flag"}, half, 1'b1);
      chk({tag, " hi_display"}, display_output, word[31:16]);
      if (am) begin
        repeat (DWELL) @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
        chk({tag, " hi_hold_no_done"}, done, 1'b0);
        pulse_step();
      end
      if (done) begin
        nregs = k + 1;
        break;
      end
      nx = e + 4'd1;
      chk({tag, " rd_addr_next"}, rd_addr, {1'b0, nx});
    end
    chk({tag, " regs_visited"}, nregs, exp_regs);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 1'b0);
    chk({tag, " busy_after"}, busy, 1'b0);
    chk({tag, " display_hold"}, display_output, word[31:16]);
    chk({tag, " cur_reg_hold"}, cur_reg, l);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] old;
    int          donecnt;
    logic [3:0]  rf;
    logic [3:0]  rl;
    logic        ram;

    tbl[0] = '{4'd5,  4'd5, 1'b0, 1};
    tbl[1] = '{4'd14, 4'd1, 1'b1, 4};
    tbl[2] = '{4'd3,  4'd2, 1'b0, 16};
    tbl[3] = '{4'd0,  4'd7, 1'b1, 8};
    tbl[4] = '{4'd9,  4'd9, 1'b1, 1};

    for (int i = 0; i < 32; i++) bank[i] = 32'(i) * 32'h0001_0001;
    bank[5] = 32'hDEAD_BEEF;

    // Reset state, and step in IDLE has no effect.
    repeat (3) @(negedge clk);
    chk("reset rd_addr", rd_addr, 5'd0);
    chk("reset display", display_output, 16'd0);
    chk("reset cur_reg", cur_reg, 4'd0);
    chk("reset half", half, 1'b0);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    pulse_step();
    repeat (2) @(negedge clk);
    chk("idle_step display", display_output, 16'd0);
    chk("idle_step busy", busy, 1'b0);
    chk("idle_step half", half, 1'b0);
    chk("idle_step rd_addr", rd_addr, 5'd0);

    for (int t = 0; t < 5; t++)
      run_dump(tbl[t].f, tbl[t].l, tbl[t].am, tbl[t].nregs, $sformatf("tbl%0d", t));

    for (int r = 0; r < 6; r++) begin
      fill_random();
      rf  = 4'($urandom_range(0, 15));
      rl  = 4'($urandom_range(0, 15));
      ram = 1'($urandom_range(0, 1));
      run_dump(rf, rl, ram, ((int'(rl) - int'(rf) + 16) % 16) + 1, $sformatf("rnd%0d", r));
    end

    // Abort together with step during SHOW_HI of reg 2.
    fill_random();
    kick(4'd0, 4'd7, 1'b0);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      pulse_step();
      pulse_step();
    end
    @(negedge clk);
    pulse_step();
    abort = 1'b1;
    step  = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    step  = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort display", display_output, bank[2][31:16]);
    chk("abort cur_reg", cur_reg, 4'd2);
    chk("abort half", half, 1'b1);
    @(negedge clk);
    chk("abort no_late_done", done, 1'b0);

    // start while busy is ignored.
    fill_random();
    kick(4'd0, 4'd3, 1'b0);
    @(negedge clk);
    pulse_step();
    pulse_step();
    @(negedge clk);
    first_reg = 4'd9;
    last_reg  = 4'd12;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart cur_reg", cur_reg, 4'd1);
    chk("restart half", half, 1'b0);
    donecnt = 0;
    for (int k = 1; k <= 3; k++) begin
      pulse_step();
      chk("restart seq cur_reg", cur_reg, 4'(k));
      chk("restart seq display", display_output, bank[k][31:16]);
      pulse_step();
      if (done) donecnt++;
      if (k < 3) @(negedge clk);
    end
    repeat (4) begin
      @(negedge clk);
      if (done) donecnt++;
    end
    chk("restart done_count", donecnt, 1);
    chk("restart busy", busy, 1'b0);
    chk("restart rd_addr_idle", rd_addr, 5'd3);

    // Bank write during SHOW_LO is not seen in the high half.
    bank[3] = 32'hCAFE_F00D;
    old     = bank[3];
    kick(4'd3, 4'd3, 1'b0);
    @(negedge clk);
    chk("snap lo", display_output, old[15:0]);
    bank[3] = 32'h1234_5678;
    pulse_step();
    chk("snap hi", display_output, old[31:16]);
    pulse_step();
    chk("snap done", done, 1'b1);
    @(negedge clk);

    // Asynchronous reset mid-dump.
    kick(4'd0, 4'd5, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst busy", busy, 1'b0);
    chk("async_rst display", display_output, 16'd0);
    chk("async_rst cur_reg", cur_reg, 4'd0);
    chk("async_rst half", half, 1'b0);
    chk("async_rst rd_addr", rd_addr, 5'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
